// File: rtl/edge_stage_sequencer.sv
// Address/control sequencer for the 20x20 edge-detection pipeline: runs the five filter
// stages in order, scanning column strips, counting results, copying borders and committing.
module edge_stage_sequencer #(
  parameter int IMG_DIM = 20,
  parameter int ADDR_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_end,
  input  logic              i_mod_ready,
  output logic [2:0]        o_op,
  output logic              o_kern5,
  output logic              o_col_valid,
  output logic [ADDR_W-1:0] o_col_addr,
  output logic              o_strip_start,
  output logic              o_wr_en,
  output logic              o_ang_we,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_bd_en,
  output logic [ADDR_W-1:0] o_bd_dst,
  output logic [ADDR_W-1:0] o_bd_src,
  output logic              o_commit,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_OP, S_PREP, S_SCAN, S_DRAIN, S_BORDER, S_COMMIT, S_DONE
  } state_t;

  localparam logic [2:0] OP_GAU = 3'd2;
  localparam logic [2:0] OP_SOB = 3'd3;
  localparam logic [2:0] OP_HYS = 3'd5;
  localparam logic [4:0] DIM_M1 = 5'(IMG_DIM - 1);

  state_t      r_state, w_state_next;
  logic [2:0]  r_op;
  logic [4:0]  r_row, r_col, r_orow, r_ocol, r_brow, r_bcol;
  logic        r_err;

  logic [4:0]  w_m, w_n, w_hi, w_src_row, w_src_col;
  logic        w_res_ok, w_brow_edge;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [4:0] row, input logic [4:0] col);
    return ADDR_W'(row) * ADDR_W'(IMG_DIM) + ADDR_W'(col);
  endfunction

  // Kernel half-width, strip count and last interior index for the active op.
  assign w_m  = (r_op == OP_GAU) ? 5'd2 : 5'd1;
  assign w_n  = 5'(IMG_DIM) - (w_m << 1);
  assign w_hi = DIM_M1 - w_m;

  // A result is accepted only while scanning/draining and before the stage total is reached.
  assign w_res_ok    = ((r_state == S_SCAN) || (r_state == S_DRAIN)) && (r_orow != w_n);
  assign w_brow_edge = (r_brow < w_m) || (r_brow > w_hi);
  assign w_src_row   = (r_brow < w_m) ? w_m : ((r_brow > w_hi) ? w_hi : r_brow);
  assign w_src_col   = (r_bcol < w_m) ? w_m : ((r_bcol > w_hi) ? w_hi : r_bcol);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    o_op          = r_op;
    o_kern5       = (r_op == OP_GAU);
    o_busy        = (r_state != S_IDLE);
    o_err         = r_err;
    o_col_valid   = 1'b0;
    o_col_addr    = '0;
    o_strip_start = 1'b0;
    o_wr_en       = i_mod_ready & w_res_ok;
    o_ang_we      = i_mod_ready & w_res_ok & (r_op == OP_SOB);
    o_wr_addr     = '0;
    o_bd_en       = 1'b0;
    o_bd_dst      = '0;
    o_bd_src      = '0;
    o_commit      = 1'b0;
    o_done        = 1'b0;
    if (o_wr_en) o_wr_addr = f_addr(r_orow + w_m, r_ocol + w_m);
    case (r_state)
      S_IDLE:   if (i_load_end) w_state_next = S_SET_OP;
      S_SET_OP: w_state_next = S_PREP;
      S_PREP: begin
        o_strip_start = 1'b1;
        w_state_next  = S_SCAN;
      end
      S_SCAN: begin
        o_col_valid = 1'b1;
        o_col_addr  = f_addr(r_row, r_col);
        if (r_col == DIM_M1) w_state_next = (r_row == w_n - 5'd1) ? S_DRAIN : S_PREP;
      end
      S_DRAIN: if (r_orow == w_n) w_state_next = (r_op == OP_HYS) ? S_DONE : S_BORDER;
      S_BORDER: begin
        o_bd_en  = 1'b1;
        o_bd_dst = f_addr(r_brow, r_bcol);
        o_bd_src = f_addr(w_src_row, w_src_col);
        if ((r_brow == DIM_M1) && (r_bcol == DIM_M1)) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        o_commit     = 1'b1;
        w_state_next = S_SET_OP;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_brow <= '0;
      r_bcol <= '0;
      r_err  <= 1'b0;
    end else begin
      if (i_mod_ready && !w_res_ok) r_err <= 1'b1;
      if (r_state == S_DONE)                                  r_op <= '0;
      else if (r_state != S_SET_OP && w_state_next == S_SET_OP) r_op <= r_op + 3'd1;
      if (r_state == S_SET_OP) begin
        r_row  <= '0;
        r_col  <= '0;
        r_orow <= '0;
        r_ocol <= '0;
        r_brow <= '0;
        r_bcol <= '0;
      end
      if (r_state == S_SCAN) begin
        if (r_col == DIM_M1) begin
          r_col <= '0;
          r_row <= r_row + 5'd1;
        end else begin
          r_col <= r_col + 5'd1;
        end
      end
      if (o_wr_en) begin
        if (r_ocol == w_n - 5'd1) begin
          r_ocol <= '0;
          r_orow <= r_orow + 5'd1;
        end else begin
          r_ocol <= r_ocol + 5'd1;
        end
      end
      // Interior rows jump straight from the left border band to the right one.
      if (r_state == S_BORDER) begin
        if (r_bcol == DIM_M1) begin
          r_bcol <= '0;
          r_brow <= r_brow + 5'd1;
        end else if (!w_brow_edge && (r_bcol == w_m - 5'd1)) begin
          r_bcol <= w_hi + 5'd1;
        end else begin
          r_bcol <= r_bcol + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Directed bench for edge_stage_sequencer: walks all five stages cycle by cycle against
// hand-derived schedules, then exercises stray results, mid-scan reset and restart.
module tb_edge_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_end = 1'b0;
  logic       mod_ready = 1'b0;
  logic [2:0] op;
  logic       kern5, col_valid, strip_start, wr_en, ang_we, bd_en, commit, busy, done, err;
  logic [8:0] col_addr, wr_addr, bd_dst, bd_src;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  edge_stage_sequencer #(.IMG_DIM(20), .ADDR_W(9)) dut (
    .i_clk(clk), .i_reset(reset), .i_load_end(load_end), .i_mod_ready(mod_ready),
    .o_op(op), .o_kern5(kern5), .o_col_valid(col_valid), .o_col_addr(col_addr),
    .o_strip_start(strip_start), .o_wr_en(wr_en), .o_ang_we(ang_we), .o_wr_addr(wr_addr),
    .o_bd_en(bd_en), .o_bd_dst(bd_dst), .o_bd_src(bd_src), .o_commit(commit),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Advance one clock, then present this cycle's inputs; outputs are read 1ns later.
  task automatic cycle(input logic ld, input logic mr);
    @(posedge clk);
    #1;
    load_end  = ld;
    mod_ready = mr;
    #1;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    checks++;
    if ({op, kern5, col_valid, col_addr, strip_start, wr_en, ang_we, wr_addr, bd_en, bd_dst,
         bd_src, commit, busy, done, err} !== 44'd0) begin
      failures++;
      $display("FAIL reset_outputs: got op=%0d busy=%b err=%b wr_en=%b col_addr=%0d, required all zero",
               op, busy, err, wr_en, col_addr);
    end
    load_end  = 1'b0;
    mod_ready = 1'b0;
    reset     = 1'b0;
    cycle(1'b0, 1'b0);
    checks++;
    if ({op, busy, err, strip_start} !== 6'd0) begin
      failures++;
      $display("FAIL reset_release_idle: got op=%0d busy=%b err=%b start=%b, required 0 0 0 0",
               op, busy, err, strip_start);
    end
  endtask

  task automatic test_full_sequence();
    cycle(1'b1, 1'b0);
    for (int opi = 1; opi <= 5; opi++) begin
      int m, k, n;
      m = (opi == 2) ? 2 : 1;
      k = 2 * m + 1;
      n = 20 - 2 * m;
      cycle(1'b0, 1'b0);
      checks++;
      if ({op, kern5, busy, col_valid, strip_start} !== {3'(opi), opi == 2, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL set_op%0d: got op=%0d kern5=%b busy=%b valid=%b start=%b, required op=%0d kern5=%b busy=1",
                 opi, op, kern5, busy, col_valid, strip_start, opi, opi == 2);
      end
      for (int s = 0; s < n; s++) begin
        cycle(1'b0, 1'b0);
        checks++;
        if ({strip_start, col_valid, wr_en} !== 3'b100) begin
          failures++;
          $display("FAIL prep op%0d s%0d: got start/valid/wr_en=%b%b%b, required 100",
                   opi, s, strip_start, col_valid, wr_en);
        end
        for (int c = 0; c < 20; c++) begin
          logic mr, ld;
          logic [8:0] exp_col, exp_wr;
          mr = (c >= k - 1);
          ld = (s == 1 && c == 5);
          exp_col = 9'(s * 20 + c);
          exp_wr  = 9'((s + m) * 20 + (c - (k - 1)) + m);
          cycle(ld, mr);
          checks++;
          if ({col_valid, strip_start, wr_en, ang_we, col_addr} !==
              {1'b1, 1'b0, mr, mr & (opi == 3), exp_col}) begin
            failures++;
            $display("FAIL scan op%0d s%0d c%0d: got valid/start/wr_en/ang_we=%b%b%b%b col_addr=%0d, required 10%b%b col_addr=%0d",
                     opi, s, c, col_valid, strip_start, wr_en, ang_we, col_addr, mr, mr & (opi == 3), exp_col);
          end
          if (mr) begin
            checks++;
            if (wr_addr !== exp_wr) begin
              failures++;
              $display("FAIL wr_addr op%0d s%0d c%0d: got %0d, required %0d", opi, s, c, wr_addr, exp_wr);
            end
          end
        end
      end
      cycle(1'b0, 1'b0);
      checks++;
      if ({col_valid, wr_en, bd_en, busy, done} !== 5'b00010) begin
        failures++;
        $display("FAIL drain op%0d: got valid/wr_en/bd_en/busy/done=%b%b%b%b%b, required 00010",
                 opi, col_valid, wr_en, bd_en, busy, done);
      end
      if (opi == 5) begin
        cycle(1'b0, 1'b0);
        checks++;
        if ({done, commit, busy, bd_en} !== 4'b1010) begin
          failures++;
          $display("FAIL hys_done: got done/commit/busy/bd_en=%b%b%b%b, required 1010", done, commit, busy, bd_en);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if ({done, busy, op} !== 5'd0) begin
          failures++;
          $display("FAIL after_done: got done=%b busy=%b op=%0d, required 0 0 0", done, busy, op);
        end
      end else begin
        for (int r = 0; r < 20; r++) begin
          for (int c = 0; c < 20; c++) begin
            if (r < m || r >= 20 - m || c < m || c >= 20 - m) begin
              logic [8:0] exp_dst, exp_src;
              exp_dst = 9'(r * 20 + c);
              exp_src = 9'(clampi(r, m, 19 - m) * 20 + clampi(c, m, 19 - m));
              cycle(1'b0, 1'b0);
              checks++;
              if ({bd_en, commit, bd_dst, bd_src} !== {1'b1, 1'b0, exp_dst, exp_src}) begin
                failures++;
                $display("FAIL border op%0d r%0d c%0d: got en=%b commit=%b dst=%0d src=%0d, required en=1 commit=0 dst=%0d src=%0d",
                         opi, r, c, bd_en, commit, bd_dst, bd_src, exp_dst, exp_src);
              end
            end
          end
        end
        cycle(1'b0, 1'b0);
        checks++;
        if ({commit, bd_en, op} !== {1'b1, 1'b0, 3'(opi)}) begin
          failures++;
          $display("FAIL commit op%0d: got commit=%b bd_en=%b op=%0d, required commit=1 bd_en=0 op=%0d",
                   opi, commit, bd_en, op, opi);
        end
      end
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL err_clean op%0d: got err=%b, required 0", opi, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if ({op, busy, kern5} !== {3'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL restart_after_done: got op=%0d busy=%b kern5=%b, required op=1 busy=1 kern5=0", op, busy, kern5);
    end
  endtask

  task automatic test_stray_border();
    load_end  = 1'b0;
    mod_ready = 1'b0;
    reset     = 1'b1;
    cycle(1'b0, 1'b0);
    reset = 1'b0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int s = 0; s < 18; s++) begin
      cycle(1'b0, 1'b0);
      for (int c = 0; c < 20; c++) cycle(1'b0, c >= 2);
    end
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    checks++;
    if ({bd_en, err} !== 2'b10) begin
      failures++;
      $display("FAIL border_before_stray: got bd_en=%b err=%b, required 1 0", bd_en, err);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if ({bd_en, wr_en, ang_we} !== 3'b100) begin
      failures++;
      $display("FAIL stray_no_write: got bd_en=%b wr_en=%b ang_we=%b, required 1 0 0", bd_en, wr_en, ang_we);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL stray_err_set: got err=%b, required 1", err);
    end
    for (int i = 5; i < 76; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if ({commit, err} !== 2'b11) begin
      failures++;
      $display("FAIL stray_commit_sticky: got commit=%b err=%b, required 1 1", commit, err);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if ({op, kern5} !== {3'd2, 1'b1}) begin
      failures++;
      $display("FAIL gau_set_op: got op=%0d kern5=%b, required op=2 kern5=1", op, kern5);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (strip_start !== 1'b1) begin
      failures++;
      $display("FAIL gau_prep: got strip_start=%b, required 1", strip_start);
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0);
    checks++;
    if ({col_valid, col_addr, err, busy} !== {1'b1, 9'd4, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL mid_scan_pre: got valid=%b col_addr=%0d err=%b busy=%b, required 1 4 1 1",
               col_valid, col_addr, err, busy);
    end
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if ({op, kern5, col_valid, col_addr, strip_start, wr_en, ang_we, wr_addr, bd_en, bd_dst,
         bd_src, commit, busy, done, err} !== 44'd0) begin
      failures++;
      $display("FAIL mid_scan_reset: got op=%0d valid=%b col_addr=%0d busy=%b err=%b, required all zero",
               op, col_valid, col_addr, busy, err);
    end
    reset = 1'b0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if ({op, busy, kern5} !== {3'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL restart_med: got op=%0d busy=%b kern5=%b, required op=1 busy=1 kern5=0", op, busy, kern5);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if ({strip_start, col_valid} !== 2'b10) begin
      failures++;
      $display("FAIL restart_prep: got start=%b valid=%b, required 1 0", strip_start, col_valid);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if ({col_valid, col_addr} !== {1'b1, 9'd0}) begin
      failures++;
      $display("FAIL restart_first_col: got valid=%b col_addr=%0d, required 1 0", col_valid, col_addr);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_back_to_back();
    test_stray_border();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
